// File: rtl/seg_display_arbiter.sv
// Seven-segment score display arbiter.
// Chooses between the live score, a blinking new-best flash and a pre-game
// countdown; the countdown has highest priority and can queue one best flash
// to play once it completes.
module seg_display_arbiter #(
   parameter int unsigned HOLD_CYCLES = 200_000_000,
   parameter int unsigned BLINK_HALF  = 25_000_000,
   parameter int unsigned STEP_CYCLES = 100_000_000,
   parameter int unsigned CD_START    = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] score,
   input  logic       best_req,
   input  logic [7:0] best_value,
   input  logic       cd_req,
   output logic [7:0] disp_value,
   output logic       disp_blank,
   output logic [1:0] disp_src,
   output logic       countdown_done,
   output logic       busy
);

   localparam int unsigned MaxHB  = (HOLD_CYCLES > BLINK_HALF) ? HOLD_CYCLES : BLINK_HALF;
   localparam int unsigned MaxCyc = (MaxHB > STEP_CYCLES) ? MaxHB : STEP_CYCLES;
   localparam int unsigned TW     = $clog2(MaxCyc) + 1;

   localparam logic [TW-1:0] HoldLast  = TW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0] BlinkLast = TW'(BLINK_HALF - 1);
   localparam logic [TW-1:0] StepLast  = TW'(STEP_CYCLES - 1);
   localparam logic [TW-1:0] TOne      = TW'(1);
   localparam logic [7:0]    CdStart   = 8'(CD_START);

   typedef enum logic [1:0] {StScore = 2'd0, StBest = 2'd1, StCount = 2'd2} state_e;

   state_e        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;   // hold timer in BEST, step timer in COUNT
   logic [TW-1:0] blink_q, blink_d;
   logic          phase_q, phase_d;   // 1 = digits lit
   logic [7:0]    best_val_q, best_val_d;
   logic          pend_q, pend_d;     // best flash queued behind the countdown
   logic [7:0]    cd_val_q, cd_val_d;
   logic          done_d;
   logic [7:0]    value_d;
   logic          blank_d;
   logic [1:0]    src_d;

   // Next-state logic: priority cd_req > best_req > timer expiry.
   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      blink_d    = blink_q;
      phase_d    = phase_q;
      best_val_d = best_val_q;
      pend_d     = pend_q;
      cd_val_d   = cd_val_q;
      done_d     = 1'b0;
      unique case (state_q)
         StScore, StBest: begin
            if (cd_req) begin
               // Any flash in progress is dropped; a coincident best_req is queued.
               state_d  = StCount;
               timer_d  = '0;
               blink_d  = '0;
               phase_d  = 1'b1;
               cd_val_d = CdStart;
               pend_d   = best_req;
               if (best_req) begin
                  best_val_d = best_value;
               end
            end else if (best_req) begin
               state_d    = StBest;
               timer_d    = '0;
               blink_d    = '0;
               phase_d    = 1'b1;
               best_val_d = best_value;
            end else if (state_q == StBest) begin
               if (timer_q == HoldLast) begin
                  state_d = StScore;
                  timer_d = '0;
                  blink_d = '0;
                  phase_d = 1'b1;
               end else begin
                  timer_d = timer_q + TOne;
                  if (blink_q == BlinkLast) begin
                     blink_d = '0;
                     phase_d = ~phase_q;
                  end else begin
                     blink_d = blink_q + TOne;
                  end
               end
            end
         end
         StCount: begin
            if (best_req) begin
               pend_d     = 1'b1;
               best_val_d = best_value;
            end
            if (timer_q == StepLast) begin
               timer_d = '0;
               if (cd_val_q == 8'd1) begin
                  done_d  = 1'b1;
                  blink_d = '0;
                  phase_d = 1'b1;
                  if (pend_d) begin
                     state_d = StBest;
                     pend_d  = 1'b0;
                  end else begin
                     state_d = StScore;
                  end
               end else begin
                  cd_val_d = cd_val_q - 8'd1;
               end
            end else begin
               timer_d = timer_q + TOne;
            end
         end
         default: state_d = StScore;
      endcase
   end

   // Output values follow the next state so they appear one cycle after the cause.
   always_comb begin
      value_d = score;
      blank_d = 1'b0;
      src_d   = 2'd0;
      unique case (state_d)
         StBest: begin
            value_d = best_val_d;
            blank_d = ~phase_d;
            src_d   = 2'd1;
         end
         StCount: begin
            value_d = cd_val_d;
            src_d   = 2'd2;
         end
         default: ;
      endcase
   end

   // State, timers and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= StScore;
         timer_q        <= '0;
         blink_q        <= '0;
         phase_q        <= 1'b0;
         best_val_q     <= '0;
         pend_q         <= 1'b0;
         cd_val_q       <= '0;
         disp_value     <= '0;
         disp_blank     <= 1'b0;
         disp_src       <= 2'd0;
         countdown_done <= 1'b0;
      end else begin
         state_q        <= state_d;
         timer_q        <= timer_d;
         blink_q        <= blink_d;
         phase_q        <= phase_d;
         best_val_q     <= best_val_d;
         pend_q         <= pend_d;
         cd_val_q       <= cd_val_d;
         disp_value     <= value_d;
         disp_blank     <= blank_d;
         disp_src       <= src_d;
         countdown_done <= done_d;
      end
   end

   assign busy = (disp_src != 2'd0);

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter: directed per-cycle stimulus pushes hand-computed
// expected outputs into a queue; a monitor pops one entry after every clock edge.
module tb_seg_display_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] score;
   logic       best_req;
   logic [7:0] best_value;
   logic       cd_req;
   logic [7:0] disp_value;
   logic       disp_blank;
   logic [1:0] disp_src;
   logic       countdown_done;
   logic       busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] v;
      logic       b;
      logic [1:0] s;
      logic       d;
      string      nm;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   seg_display_arbiter #(
      .HOLD_CYCLES(20),
      .BLINK_HALF (5),
      .STEP_CYCLES(10),
      .CD_START   (3)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .score         (score),
      .best_req      (best_req),
      .best_value    (best_value),
      .cd_req        (cd_req),
      .disp_value    (disp_value),
      .disp_blank    (disp_blank),
      .disp_src      (disp_src),
      .countdown_done(countdown_done),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   // Apply one cycle of inputs and queue the outputs expected after the next edge.
   task automatic drive(input bit r, input logic [7:0] sc, input bit br, input logic [7:0] bv,
                        input bit cr, input logic [7:0] ev, input bit eb, input logic [1:0] es,
                        input bit ed, input string nm);
      exp_t e;
      @(negedge clk);
      rst        = r;
      score      = sc;
      best_req   = br;
      best_value = bv;
      cd_req     = cr;
      e.v = ev; e.b = eb; e.s = es; e.d = ed; e.nm = nm;
      exp_q.push_back(e);
   endtask

   // Monitor: one comparison per clock edge while expectations are queued.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         checks++;
         if (disp_value !== mon_e.v || disp_blank !== mon_e.b || disp_src !== mon_e.s ||
             countdown_done !== mon_e.d || busy !== (mon_e.s != 2'd0)) begin
            errors++;
            $display("FAIL %s t=%0t: got val=%0d blank=%b src=%0d done=%b busy=%b want val=%0d blank=%b src=%0d done=%b busy=%b",
                     mon_e.nm, $time, disp_value, disp_blank, disp_src, countdown_done, busy,
                     mon_e.v, mon_e.b, mon_e.s, mon_e.d, (mon_e.s != 2'd0));
         end
      end
   end

   // Expected blinking flash of value v for cycles 1..19 after entry (entry cycle excluded).
   task automatic flash_tail(input logic [7:0] sc, input logic [7:0] v, input string nm);
      for (int i = 1; i < 20; i++) begin
         drive(0, sc, 0, 0, 0, v, ((i / 5) % 2) == 1, 2'd1, 0, nm);
      end
   endtask

   initial begin
      rst = 1'b1; score = '0; best_req = 1'b0; best_value = '0; cd_req = 1'b0;

      // 1: reset and live score
      drive(1, 0, 0, 0, 0, 0, 0, 2'd0, 0, "reset");
      drive(1, 0, 0, 0, 0, 0, 0, 2'd0, 0, "reset");
      drive(0, 42, 0, 0, 0, 42, 0, 2'd0, 0, "score42");
      drive(0, 7, 0, 0, 0, 7, 0, 2'd0, 0, "score7");

      // 2: best flash 57, blink 5 on / 5 off, 20 cycles total
      drive(0, 7, 1, 57, 0, 57, 0, 2'd1, 0, "best_enter");
      flash_tail(7, 57, "best_blink");
      drive(0, 7, 0, 0, 0, 7, 0, 2'd0, 0, "best_end");

      // 3: retrigger at cycle 10 with 60
      drive(0, 7, 1, 57, 0, 57, 0, 2'd1, 0, "retrig_enter");
      for (int i = 1; i < 10; i++) begin
         drive(0, 7, 0, 0, 0, 57, i >= 5, 2'd1, 0, "retrig_first");
      end
      drive(0, 7, 1, 60, 0, 60, 0, 2'd1, 0, "retrig_new");
      flash_tail(7, 60, "retrig_blink");
      drive(0, 7, 0, 0, 0, 7, 0, 2'd0, 0, "retrig_end");

      // 4: countdown 3,2,1 with an ignored extra cd_req
      drive(0, 5, 0, 0, 1, 3, 0, 2'd2, 0, "cd_start");
      for (int i = 1; i < 30; i++) begin
         drive(0, 5, 0, 0, (i == 5), 8'(3 - i / 10), 0, 2'd2, 0, "cd_run");
      end
      drive(0, 5, 0, 0, 0, 5, 0, 2'd0, 1, "cd_done");
      drive(0, 5, 0, 0, 0, 5, 0, 2'd0, 0, "cd_after");

      // 5: coincident cd_req and best_req 99: countdown then flash
      drive(0, 5, 1, 99, 1, 3, 0, 2'd2, 0, "pend_start");
      for (int i = 1; i < 30; i++) begin
         drive(0, 5, 0, 0, 0, 8'(3 - i / 10), 0, 2'd2, 0, "pend_cd");
      end
      drive(0, 5, 0, 0, 0, 99, 0, 2'd1, 1, "pend_done_best");
      flash_tail(5, 99, "pend_blink");
      drive(0, 5, 0, 0, 0, 5, 0, 2'd0, 0, "pend_end");

      // 6: rst mid-countdown, then cd_req preempting a flash
      drive(0, 9, 0, 0, 1, 3, 0, 2'd2, 0, "abort_start");
      for (int i = 1; i < 15; i++) begin
         drive(0, 9, 0, 0, 0, 8'(3 - i / 10), 0, 2'd2, 0, "abort_cd");
      end
      drive(1, 9, 0, 0, 0, 0, 0, 2'd0, 0, "abort_rst");
      for (int i = 0; i < 35; i++) begin
         drive(0, 9, 0, 0, 0, 9, 0, 2'd0, 0, "abort_nodone");
      end
      drive(0, 9, 1, 11, 0, 11, 0, 2'd1, 0, "preempt_best");
      drive(0, 9, 0, 0, 0, 11, 0, 2'd1, 0, "preempt_best");
      drive(0, 9, 0, 0, 1, 3, 0, 2'd2, 0, "preempt_cd");
      for (int i = 1; i < 30; i++) begin
         drive(0, 9, 0, 0, 0, 8'(3 - i / 10), 0, 2'd2, 0, "preempt_run");
      end
      drive(0, 9, 0, 0, 0, 9, 0, 2'd0, 1, "preempt_done");
      drive(0, 9, 0, 0, 0, 9, 0, 2'd0, 0, "preempt_score");

      repeat (2) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending entries want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
